// File: rtl/if_prefetch.sv
// if_prefetch: sequential instruction fetch with a prefetch FIFO.
// Fetches run ahead of decode over a classic Wishbone master port. Each
// fetched word is queued together with its PC. A redirect flushes the queue
// and restarts fetch; a bus cycle already in flight is allowed to finish
// and its data is thrown away.
// Optional build macro IF_PREFETCH_ERR_EN adds wb_err_i / inst_fault.
module if_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(32'h8000_0000)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   inst_data,
    output logic [ADDR_WIDTH-1:0]   inst_pc,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
`ifdef IF_PREFETCH_ERR_EN
    input  logic                    wb_err_i,
    output logic                    inst_fault,
`endif
    output logic                    wb_we_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  halted;     // set after a faulting fetch, cleared by redirect
    logic                  bus_err;
    logic                  bus_term;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW:0]           count;

`ifdef IF_PREFETCH_ERR_EN
    logic                  mem_fault [FIFO_DEPTH];
    assign bus_err = wb_err_i;
`else
    assign bus_err = 1'b0;
`endif

    assign bus_term  = wb_ack_i | bus_err;
    // Only a live request (not one being dropped) lands in the FIFO.
    assign push      = (state == REQ) && bus_term && !redirect_valid;
    assign pop       = inst_valid && inst_ready;
    assign push_data = bus_err ? '0 : wb_dat_i;

    assign wb_dat_o   = '0;
    assign wb_we_o    = 1'b0;
    assign inst_valid = (count != '0);
    assign inst_data  = mem_data[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];
`ifdef IF_PREFETCH_ERR_EN
    assign inst_fault = mem_fault[rd_ptr];
`endif

    // Fetch FSM: issues one request at a time, drops data after a redirect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= PC_RESET;
            halted   <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc & ALIGN_MASK;
            case (state)
                IDLE: begin
                    if (!redirect_valid && !halted && count < (PW+1)'(FIFO_DEPTH)) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_adr_o <= fetch_pc;
                        wb_sel_o <= '1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (bus_term) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        state    <= IDLE;
                        if (!redirect_valid) begin
                            if (bus_err) halted   <= 1'b1;
                            else         fetch_pc <= fetch_pc + ADDR_WIDTH'(BYTES);
                        end
                    end else if (redirect_valid) begin
                        // Wishbone cycles cannot be aborted: finish it and discard.
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (bus_term) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (redirect_valid)
                halted <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue outright.
    always_ff @(posedge clk) begin
        if (!reset_n || redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= push_data;
            mem_pc[wr_ptr]    <= wb_adr_o;
`ifdef IF_PREFETCH_ERR_EN
            mem_fault[wr_ptr] <= bus_err;
`endif
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed tests for if_prefetch with a queue-based
// reference model checked every cycle, plus literal expectations.
module tb_if_prefetch;
    localparam int DEPTH = 4;
    localparam logic [31:0] PCR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_data, inst_pc;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        bus_err, fault, wait_done;

    int          ws = 0;
    int          wcnt = 0;
    logic [31:0] err_adr = 32'hFFFF_FFFF;
    int          errors = 0, checks = 0, nreads = 0;
    logic [31:0] last_adr = '0;

    always #5 clk = ~clk;

    if_prefetch dut (
        .clk(clk), .reset_n(reset_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o),
`ifdef IF_PREFETCH_ERR_EN
        .wb_err_i(bus_err), .inst_fault(fault),
`endif
        .wb_we_o(wb_we_o)
    );

    // Memory: data = address, programmable wait states, optional error address.
    assign wait_done = wb_cyc_o && wb_stb_o && (wcnt >= ws);
`ifdef IF_PREFETCH_ERR_EN
    assign bus_err = wait_done && (wb_adr_o == err_adr);
`else
    assign bus_err = 1'b0;
    assign fault   = 1'b0;
`endif
    assign wb_ack_i = wait_done && !bus_err;
    assign wb_dat_i = wb_adr_o;

    always @(posedge clk)
        if (!wb_cyc_o || wb_ack_i || bus_err) wcnt <= 0;
        else                                 wcnt <= wcnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents and next expected fetch PC.
    typedef struct packed { logic [31:0] pc; logic [31:0] data; logic fault; } ent_t;
    ent_t        q[$];
    logic [31:0] mpc = PCR;
    logic        drop = 1'b0, halted = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        if (!reset_n) begin
            q.delete(); mpc = PCR; drop = 1'b0; halted = 1'b0; nreads = 0;
        end else begin
            if (wb_ack_i || bus_err) begin nreads++; last_adr = wb_adr_o; end
            if (redirect_valid) begin
                q.delete();
                mpc    = redirect_pc & ~32'h3;
                drop   = wb_cyc_o && !(wb_ack_i || bus_err);
                halted = 1'b0;
            end else begin
                if (q.size() != 0 && inst_ready) void'(q.pop_front());
                if (wb_ack_i || bus_err) begin
                    if (drop) drop = 1'b0;
                    else if (bus_err) begin
                        e.pc = mpc; e.data = '0; e.fault = 1'b1;
                        q.push_back(e); halted = 1'b1;
                    end else begin
                        e.pc = mpc; e.data = mpc; e.fault = 1'b0;
                        q.push_back(e); mpc = mpc + 32'd4;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("valid", inst_valid, q.size() != 0);
            chk("occupancy", q.size() <= DEPTH, 1'b1);
            if (q.size() != 0) begin
                chk("pc", inst_pc, q[0].pc);
                chk("data", inst_data, q[0].data);
                chk("fault", fault, q[0].fault);
            end
            chk("stb", wb_stb_o, wb_cyc_o);
            chk("sel", wb_sel_o, wb_cyc_o ? 4'hF : 4'h0);
            chk("we", wb_we_o, 1'b0);
            chk("dat_o", wb_dat_o, 32'h0);
            if (wb_cyc_o && !drop) chk("adr", wb_adr_o, mpc);
            if (q.size() == DEPTH) chk("full_idle", wb_cyc_o, 1'b0);
            if (halted) chk("halt_idle", wb_cyc_o, 1'b0);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int lim, output int k);
        k = 0;
        while (!inst_valid && k < lim) begin @(negedge clk); k++; end
    endtask

    task automatic wait_cyc_rise();
        int k = 0;
        while (wb_cyc_o && k < 40) begin @(negedge clk); k++; end
        while (!wb_cyc_o && k < 80) begin @(negedge clk); k++; end
        chk("cyc_rise", wb_cyc_o, 1'b1);
    endtask

    initial begin
        int k;
        // Reset state
        @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_valid", inst_valid, 1'b0);

        // T1: zero-wait streaming, in-order PCs, latency
        @(negedge clk); inst_ready = 1'b1; reset_n = 1'b1;
        wait_valid(20, k);
        chk("t1_latency", k, 2);
        for (int i = 0; i < 3; i++) begin
            wait_valid(10, k);
            chk("t1_pc", inst_pc, 32'(PCR + 4 * i));
            chk("t1_data", inst_data, 32'(PCR + 4 * i));
            @(negedge clk);
        end

        // T2: stalled decode fills exactly DEPTH entries
        inst_ready = 1'b0; do_reset();
        repeat (30) @(negedge clk);
        chk("t2_reads", nreads, 4);
        chk("t2_last_adr", last_adr, 32'h8000_000C);
        chk("t2_cyc_idle", wb_cyc_o, 1'b0);
        chk("t2_head", inst_pc, 32'h8000_0000);
        inst_ready = 1'b1; @(negedge clk); inst_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("t2_reads_after_pop", nreads, 5);
        chk("t2_adr_after_pop", last_adr, 32'h8000_0010);
        chk("t2_cyc_idle2", wb_cyc_o, 1'b0);
        chk("t2_head2", inst_pc, 32'h8000_0004);

        // T3: redirect mid-request with late ack, stale word dropped
        ws = 3; inst_ready = 1'b1;
        wait_cyc_rise();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
        @(negedge clk); redirect_valid = 1'b0;
        chk("t3_empty", inst_valid, 1'b0);
        chk("t3_bus_held", wb_cyc_o, 1'b1);
        wait_valid(40, k);
        chk("t3_pc", inst_pc, 32'h8000_0100);
        chk("t3_data", inst_data, 32'h8000_0100);

        // T4: redirect coincident with ack and pop
        ws = 1; inst_ready = 1'b0;
        k = 0;
        while (!(wb_ack_i && inst_valid) && k < 40) begin @(negedge clk); k++; end
        chk("t4_sync", wb_ack_i && inst_valid, 1'b1);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        @(negedge clk); redirect_valid = 1'b0;
        chk("t4_empty", inst_valid, 1'b0);
        chk("t4_cyc", wb_cyc_o, 1'b0);
        wait_valid(40, k);
        chk("t4_pc", inst_pc, 32'h8000_0200);

        // T5: reset during a request
        ws = 3;
        wait_cyc_rise();
        reset_n = 1'b0;
        @(negedge clk);
        chk("t5_cyc", wb_cyc_o, 1'b0);
        chk("t5_stb", wb_stb_o, 1'b0);
        chk("t5_valid", inst_valid, 1'b0);
        reset_n = 1'b1;
        wait_valid(40, k);
        chk("t5_pc", inst_pc, 32'h8000_0000);

`ifdef IF_PREFETCH_ERR_EN
        // T6: bus error halts fetch until redirect
        ws = 0; err_adr = 32'h8000_0008; inst_ready = 1'b1;
        do_reset();
        k = 0;
        while (!(inst_valid && fault) && k < 40) begin @(negedge clk); k++; end
        chk("t6_fault", fault, 1'b1);
        chk("t6_pc", inst_pc, 32'h8000_0008);
        chk("t6_data", inst_data, 32'h0);
        repeat (10) @(negedge clk);
        chk("t6_reads", nreads, 3);
        chk("t6_cyc", wb_cyc_o, 1'b0);
        err_adr = 32'hFFFF_FFFF;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
        @(negedge clk); redirect_valid = 1'b0;
        wait_valid(40, k);
        chk("t6_resume_pc", inst_pc, 32'h8000_0000);
        chk("t6_resume_fault", fault, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
